// File: rtl/sram_axi_bridge_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_pkg
// Purpose  : Shared AXI3 constants, SRAM size encodings and write FSM states
// Revision : 1.0
// ============================================================================
package sram_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'h00;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_axi_bridge_mp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin one-hot arbiter; pointer moves past each grantee
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  int               best_dist;

  // Distance of a requester from the pointer; smallest distance wins.
  function automatic int dist_of(input int idx, input logic [PTR_W-1:0] p);
    return (idx + N - int'(p)) % N;
  endfunction

  always_comb begin
    best_dist = N;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (dist_of(i, ptr_q) < best_dist)) begin
        best_dist = dist_of(i, ptr_q);
      end
    end
    grant = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (enable && req[i] && (dist_of(i, ptr_q) == best_dist)) begin
        grant[i] = 1'b1;
        ptr_d    = PTR_W'((i + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_axi_bridge_mp.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge_mp
// Purpose  : NUM_PORTS SRAM-like masters onto one AXI3 master, port index = ID
// Revision : 1.0
// ============================================================================
module sram_axi_bridge_mp
  import sram_axi_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_RD    = 2,
  parameter int ID_W      = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_PORTS-1:0]    port_req,
  input  logic [NUM_PORTS-1:0]    port_wr,
  input  logic [2*NUM_PORTS-1:0]  port_size,
  input  logic [4*NUM_PORTS-1:0]  port_wstrb,
  input  logic [32*NUM_PORTS-1:0] port_addr,
  input  logic [32*NUM_PORTS-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]    port_addr_ok,
  output logic [NUM_PORTS-1:0]    port_data_ok,
  output logic [32*NUM_PORTS-1:0] port_rdata,
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ID_W-1:0]         awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_W-1:0]         wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(MAX_RD);

  logic             ar_valid_q, ar_valid_d;
  logic [ID_W-1:0]  ar_id_q, ar_id_d;
  logic [31:0]      ar_addr_q, ar_addr_d;
  logic [1:0]       ar_size_q, ar_size_d;
  logic [CNT_W-1:0] rd_cnt_q [NUM_PORTS];
  logic [CNT_W-1:0] rd_cnt_d [NUM_PORTS];
  logic             rready_q, rready_d;

  w_state_e         w_state_q, w_state_d;
  logic [ID_W-1:0]  w_id_q, w_id_d;
  logic [31:0]      w_addr_q, w_addr_d;
  logic [1:0]       w_size_q, w_size_d;
  logic [3:0]       w_strb_q, w_strb_d;
  logic [31:0]      w_data_q, w_data_d;
  logic             aw_valid_q, aw_valid_d;
  logic             w_valid_q, w_valid_d;
  logic             bready_q, bready_d;

  logic [NUM_PORTS-1:0] elig, grant, r_hit, b_hit;
  logic                 ar_free, w_busy;
  logic                 gnt_rd, gnt_wr;
  logic [ID_W-1:0]      gnt_id;
  logic [31:0]          gnt_addr, gnt_data;
  logic [1:0]           gnt_size;
  logic [3:0]           gnt_strb;
  logic                 unused_ok;

  assign unused_ok = ^{rresp, rlast, bresp};
  assign ar_free   = !ar_valid_q || arready;
  assign w_busy    = (w_state_q != W_IDLE);

  // Reads to the in-flight write's word are held off until its response.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = (port_req[i] && !port_wr[i] && ar_free && (rd_cnt_q[i] < RD_LIMIT)
                 && !(w_busy && (w_id_q == ID_W'(i)))
                 && !(w_busy && (port_addr[32*i+2 +: 30] == w_addr_q[31:2])))
             || (port_req[i] && port_wr[i] && !w_busy && (rd_cnt_q[i] == '0));
    end
  end

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk    (aclk),
    .rst_n  (aresetn),
    .req    (elig),
    .enable (aresetn),
    .grant  (grant)
  );

  always_comb begin
    gnt_rd   = 1'b0;
    gnt_wr   = 1'b0;
    gnt_id   = '0;
    gnt_addr = '0;
    gnt_data = '0;
    gnt_size = '0;
    gnt_strb = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        gnt_rd   = !port_wr[i];
        gnt_wr   = port_wr[i];
        gnt_id   = ID_W'(i);
        gnt_addr = port_addr[32*i +: 32];
        gnt_data = port_wdata[32*i +: 32];
        gnt_size = port_size[2*i +: 2];
        gnt_strb = port_wstrb[4*i +: 4];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign r_hit[g] = rvalid && rready_q && (rid == ID_W'(g));
      assign b_hit[g] = bvalid && bready_q && (bid == ID_W'(g));
      assign port_data_ok[g]        = r_hit[g] || b_hit[g];
      assign port_rdata[32*g +: 32] = rdata;
    end
  endgenerate

  assign port_addr_ok = grant;

  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    rready_d   = 1'b1;
    if (gnt_rd) begin
      ar_valid_d = 1'b1;
      ar_id_d    = gnt_id;
      ar_addr_d  = gnt_addr;
      ar_size_d  = gnt_size;
    end else if (arready) begin
      ar_valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      rd_cnt_d[i] = rd_cnt_q[i] + CNT_W'(grant[i] && !port_wr[i]) - CNT_W'(r_hit[i]);
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    w_addr_d   = w_addr_q;
    w_size_d   = w_size_q;
    w_strb_d   = w_strb_q;
    w_data_d   = w_data_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    bready_d   = bready_q;
    case (w_state_q)
      W_IDLE: begin
        if (gnt_wr) begin
          w_id_d     = gnt_id;
          w_addr_d   = gnt_addr;
          w_size_d   = gnt_size;
          w_strb_d   = gnt_strb;
          w_data_d   = gnt_data;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          w_state_d  = W_REQ;
        end
      end
      W_REQ: begin
        if (awready) aw_valid_d = 1'b0;
        if (wready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          bready_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          bready_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      rready_q   <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) rd_cnt_q[i] <= '0;
      w_state_q  <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_size_q   <= '0;
      w_strb_q   <= '0;
      w_data_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      rready_q   <= rready_d;
      for (int i = 0; i < NUM_PORTS; i++) rd_cnt_q[i] <= rd_cnt_d[i];
      w_state_q  <= w_state_d;
      w_id_q     <= w_id_d;
      w_addr_q   <= w_addr_d;
      w_size_q   <= w_size_d;
      w_strb_q   <= w_strb_d;
      w_data_q   <= w_data_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      bready_q   <= bready_d;
    end
  end

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = axi_size(ar_size_q);
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = ar_valid_q;
  assign rready  = rready_q;

  assign awid    = w_id_q;
  assign awaddr  = w_addr_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = axi_size(w_size_q);
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = aw_valid_q;
  assign wid     = w_id_q;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = w_valid_q;
  assign bready  = bready_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_axi_bridge_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_axi_bridge_mp
// Purpose  : Directed vector table plus hand sequences for write/hazard/reset
// Revision : 1.0
// ============================================================================
module tb_sram_axi_bridge_mp;
  import sram_axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [1:0]  port_req, port_wr, port_addr_ok, port_data_ok;
  logic [3:0]  port_size;
  logic [7:0]  port_wstrb;
  logic [63:0] port_addr, port_wdata, port_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;

  sram_axi_bridge_mp #(.NUM_PORTS(2), .MAX_RD(2), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .port_req(port_req), .port_wr(port_wr), .port_size(port_size),
    .port_wstrb(port_wstrb), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_addr_ok(port_addr_ok), .port_data_ok(port_data_ok), .port_rdata(port_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          rst;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        arready;
    logic        rvalid;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  e_aok;
    logic [1:0]  e_dok;
    logic        e_arv;
    logic [3:0]  e_arid;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    port_req = '0; port_wr = '0; port_size = {SIZE_BYTE, SIZE_BYTE};
    port_wstrb = '0; port_addr = '0; port_wdata = '0;
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
    bvalid = 0; bid = '0; bresp = '0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    idle();
    #2 aresetn = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    idle();
    #1 aresetn = 1'b0;
    port_req = 2'b11; rvalid = 1'b1;
    #1;
    check("rst arvalid", arvalid, 0);
    check("rst awvalid", awvalid, 0);
    check("rst wvalid", wvalid, 0);
    check("rst bready", bready, 0);
    check("rst rready", rready, 0);
    check("rst addr_ok", port_addr_ok, 0);
    check("rst data_ok", port_data_ok, 0);
    idle();
    @(negedge aclk);
    aresetn = 1'b1;

    //          rst req    a0            a1          ard rv rid rdata          aok    dok    arv arid
    vecs[0]  = '{1, 2'b01, 32'h1C000000, 32'h0,      1, 0, 0, 32'h0,         2'b01, 2'b00, 0, 0};
    vecs[1]  = '{0, 2'b00, 32'h1C000000, 32'h0,      1, 0, 0, 32'h0,         2'b00, 2'b00, 1, 0};
    vecs[2]  = '{0, 2'b00, 32'h1C000000, 32'h0,      1, 1, 0, 32'hDEADBEEF,  2'b00, 2'b01, 0, 0};
    vecs[3]  = '{0, 2'b00, 32'h1C000000, 32'h0,      1, 0, 0, 32'h0,         2'b00, 2'b00, 0, 0};
    vecs[4]  = '{1, 2'b11, 32'h1000,     32'h2000,   1, 0, 0, 32'h0,         2'b01, 2'b00, 0, 0};
    vecs[5]  = '{0, 2'b11, 32'h1000,     32'h2000,   1, 0, 0, 32'h0,         2'b10, 2'b00, 1, 0};
    vecs[6]  = '{0, 2'b11, 32'h1000,     32'h2000,   1, 0, 0, 32'h0,         2'b01, 2'b00, 1, 1};
    vecs[7]  = '{0, 2'b11, 32'h1000,     32'h2000,   1, 0, 0, 32'h0,         2'b10, 2'b00, 1, 0};
    vecs[8]  = '{0, 2'b11, 32'h1000,     32'h2000,   1, 0, 0, 32'h0,         2'b00, 2'b00, 1, 1};
    vecs[9]  = '{0, 2'b11, 32'h1000,     32'h2000,   1, 1, 1, 32'h11111111,  2'b00, 2'b10, 0, 0};
    vecs[10] = '{0, 2'b11, 32'h1000,     32'h2000,   1, 0, 0, 32'h0,         2'b10, 2'b00, 0, 0};
    vecs[11] = '{0, 2'b11, 32'h1000,     32'h2000,   1, 1, 0, 32'h22222222,  2'b00, 2'b01, 1, 1};
    vecs[12] = '{0, 2'b00, 32'h1000,     32'h2000,   1, 1, 0, 32'h33333333,  2'b00, 2'b01, 0, 0};
    vecs[13] = '{0, 2'b00, 32'h1000,     32'h2000,   1, 1, 1, 32'h44444444,  2'b00, 2'b10, 0, 0};
    vecs[14] = '{0, 2'b00, 32'h1000,     32'h2000,   1, 1, 1, 32'h55555555,  2'b00, 2'b10, 0, 0};

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge aclk);
      port_req  = vecs[i].req;
      port_wr   = 2'b00;
      port_size = {SIZE_WORD, SIZE_WORD};
      port_addr = {vecs[i].a1, vecs[i].a0};
      arready   = vecs[i].arready;
      rvalid    = vecs[i].rvalid;
      rid       = vecs[i].rid;
      rdata     = vecs[i].rdata;
      #1;
      check($sformatf("v%0d addr_ok", i), port_addr_ok, vecs[i].e_aok);
      check($sformatf("v%0d data_ok", i), port_data_ok, vecs[i].e_dok);
      check($sformatf("v%0d arvalid", i), arvalid, vecs[i].e_arv);
      if (vecs[i].e_arv) begin
        check($sformatf("v%0d arid", i), arid, vecs[i].e_arid);
        check($sformatf("v%0d araddr", i), araddr, (vecs[i].e_arid == 0) ? vecs[i].a0 : vecs[i].a1);
        check($sformatf("v%0d arsize", i), arsize, 3'd2);
        check($sformatf("v%0d arlen", i), arlen, 8'd0);
        check($sformatf("v%0d arburst", i), arburst, 2'b01);
      end
      for (int p = 0; p < 2; p++) begin
        if (vecs[i].e_dok[p]) check($sformatf("v%0d rdata%0d", i, p), port_rdata[32*p +: 32], vecs[i].rdata);
      end
    end

    // Write with awready delayed, wready immediate
    do_reset();
    @(negedge aclk);
    idle(); wready = 1'b1;
    port_req = 2'b10; port_wr = 2'b10; port_addr = {32'h100, 32'h0};
    port_size = {SIZE_HALF, SIZE_BYTE}; port_wstrb = {4'b0011, 4'h0};
    port_wdata = {32'hCAFEBABE, 32'h0};
    #1 check("wr grant", port_addr_ok, 2'b10);
    @(negedge aclk);
    port_req = 0; port_wr = 0;
    #1;
    check("wr awvalid c1", awvalid, 1);
    check("wr wvalid c1", wvalid, 1);
    check("wr awid", awid, 1);
    check("wr wid", wid, 1);
    check("wr awaddr", awaddr, 32'h100);
    check("wr awsize", awsize, 3'd1);
    check("wr wstrb", wstrb, 4'b0011);
    check("wr wdata", wdata, 32'hCAFEBABE);
    check("wr wlast", wlast, 1);
    check("wr awlen", awlen, 0);
    @(negedge aclk);
    #1;
    check("wr awvalid c2", awvalid, 1);
    check("wr wvalid c2", wvalid, 0);
    @(negedge aclk);
    awready = 1'b1;
    #1;
    check("wr awvalid c3", awvalid, 1);
    check("wr bready c3", bready, 0);
    @(negedge aclk);
    awready = 1'b0;
    #1;
    check("wr awvalid c4", awvalid, 0);
    check("wr bready c4", bready, 1);
    check("wr data_ok early", port_data_ok, 2'b00);
    @(negedge aclk);
    bvalid = 1'b1; bid = 4'd1;
    #1 check("wr data_ok", port_data_ok, 2'b10);
    @(negedge aclk);
    bvalid = 1'b0; bid = 4'd0;
    #1;
    check("wr bready done", bready, 0);
    check("wr data_ok done", port_data_ok, 2'b00);

    // Read-after-write hazard on 0x200; 0x204 must not be blocked
    @(negedge aclk);
    idle();
    port_req = 2'b10; port_wr = 2'b10; port_addr = {32'h200, 32'h200};
    port_size = {SIZE_WORD, SIZE_WORD}; port_wstrb = 8'hF0; port_wdata = {32'h12345678, 32'h0};
    #1 check("haz wr grant", port_addr_ok, 2'b10);
    @(negedge aclk);
    port_req = 2'b01; port_wr = 2'b00; awready = 1'b1; wready = 1'b1;
    #1;
    check("haz blocked 1", port_addr_ok, 2'b00);
    check("haz awvalid", awvalid, 1);
    check("haz wvalid", wvalid, 1);
    @(negedge aclk);
    awready = 1'b0; wready = 1'b0;
    #1;
    check("haz blocked 2", port_addr_ok, 2'b00);
    check("haz bready", bready, 1);
    @(negedge aclk);
    bvalid = 1'b1; bid = 4'd1;
    #1;
    check("haz b data_ok", port_data_ok, 2'b10);
    check("haz blocked 3", port_addr_ok, 2'b00);
    @(negedge aclk);
    bvalid = 1'b0; bid = 4'd0;
    #1 check("haz read released", port_addr_ok, 2'b01);
    @(negedge aclk);
    port_req = 2'b10; port_wr = 2'b10; arready = 1'b1;
    #1;
    check("haz wr2 grant", port_addr_ok, 2'b10);
    check("haz arvalid", arvalid, 1);
    check("haz araddr", araddr, 32'h200);
    @(negedge aclk);
    port_req = 2'b01; port_wr = 2'b00; port_addr = {32'h200, 32'h204};
    #1 check("haz 204 granted", port_addr_ok, 2'b01);

    // Async reset with write in W_REQ and two reads outstanding on port 0
    @(negedge aclk);
    port_req = 2'b00; arready = 1'b0;
    #1;
    check("pre-rst arvalid", arvalid, 1);
    check("pre-rst araddr", araddr, 32'h204);
    check("pre-rst awvalid", awvalid, 1);
    check("pre-rst wvalid", wvalid, 1);
    #1 aresetn = 1'b0;
    #1;
    check("mid-rst arvalid", arvalid, 0);
    check("mid-rst awvalid", awvalid, 0);
    check("mid-rst wvalid", wvalid, 0);
    check("mid-rst bready", bready, 0);
    check("mid-rst rready", rready, 0);
    port_req = 2'b01;
    #1 check("mid-rst addr_ok", port_addr_ok, 2'b00);
    port_req = 2'b00;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1 check("post-rst rready", rready, 1);
    port_req = 2'b11; port_wr = 2'b00; port_addr = {32'h400, 32'h300}; arready = 1'b1;
    #1 check("post-rst grant0", port_addr_ok, 2'b01);
    @(negedge aclk);
    #1;
    check("post-rst grant1", port_addr_ok, 2'b10);
    check("post-rst arid", arid, 0);
    check("post-rst araddr", araddr, 32'h300);
    @(negedge aclk);
    #1 check("post-rst grant2", port_addr_ok, 2'b01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_axi_bridge_mp.md
Name: sram_axi_bridge_mp

Overview:
Multi-port successor to the single inst/data SRAM-to-AXI bridge. It connects NUM_PORTS SRAM-like master ports (req/addr_ok/data_ok) to one AXI3 master interface. It adds round-robin arbitration, up to MAX_RD reads in flight per port, port-indexed AXI IDs, and read-after-write address hazard blocking. It sits between the CPU core (or cores/DMA) and the AXI interconnect, inside the top wrapper.

Parameters:
NUM_PORTS, 2, number of SRAM-like ports (1..16); port index is the AXI ID.
MAX_RD, 2, maximum outstanding reads per port (1..7).
ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_PORTS.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
port_req  in  NUM_PORTS  per-port request
port_wr  in  NUM_PORTS  1=write
port_size  in  2*NUM_PORTS  0=byte,1=half,2=word
port_wstrb  in  4*NUM_PORTS  byte strobes
port_addr  in  32*NUM_PORTS  address
port_wdata  in  32*NUM_PORTS  write data
port_addr_ok  out  NUM_PORTS  request accepted this cycle
port_data_ok  out  NUM_PORTS  read data / write completion this cycle
port_rdata  out  32*NUM_PORTS  read data, valid with data_ok
arid,araddr,arlen,arsize,arburst,arlock,arcache,arprot,arvalid / arready  out/in  4,32,8,3,2,2,4,3,1 / 1  AXI3 read address
rid,rdata,rresp,rlast,rvalid / rready  in/out  4,32,2,1,1 / 1  AXI3 read data
awid..awvalid / awready  out/in  same widths as AR  AXI3 write address
wid,wdata,wstrb,wlast,wvalid / wready  out/in  4,32,4,1,1 / 1
bid,bresp,bvalid / bready  in/out  4,2,1 / 1

Behaviour:
- Reset (aresetn=0, async): arvalid, awvalid, wvalid, bready = 0. rready = 0. All port_addr_ok/data_ok = 0. Read counters = 0. Write FSM = W_IDLE. RR pointer = 0. Reset mid-transaction abandons all in-flight AXI traffic.
- After reset rready = 1 constantly; SRAM-like ports cannot backpressure.
- Constant fields: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1, arsize/awsize={1'b0,size}.
- Arbitration: at most one addr_ok per cycle across all ports. Round-robin among eligible ports starting at the RR pointer; the pointer moves to grantee+1 mod NUM_PORTS on each grant.
- Read eligibility, port i: req&!wr, the AR holding register is empty or being accepted this cycle, rd_cnt[i] < MAX_RD, port i has no write in flight, and addr[31:2] does not match the in-flight write address.
- Write eligibility, port i: req&wr, write FSM in W_IDLE, rd_cnt[i]==0.
- Read path: on grant, addr_ok[i]=1 combinationally. The AR register loads {i,addr,size} and arvalid=1 from the next cycle until the arready handshake. Back-to-back grants are allowed when arready=1. rd_cnt[i]++ on grant.
- R: on rvalid with rid=i, data_ok[i]=1 and port_rdata[i]=rdata in the same cycle (combinational); rd_cnt[i]--. Increment and decrement in the same cycle leave the count unchanged. rresp is ignored.
- Write FSM:
  - W_IDLE: on grant, latch {i,addr,size,wstrb,wdata} -> W_REQ.
  - W_REQ: awvalid and wvalid are asserted together. Each drops independently on its own handshake. When both handshakes are done (either order or same cycle) -> W_RESP.
  - W_RESP: bready=1. On bvalid, data_ok[bid]=1 -> W_IDLE.
  - One write is in flight at a time.
- Per-port responses stay in order. A port never receives two data_ok in one cycle, because read and write are mutually exclusive per port.
- The address register holds its value while arvalid/awvalid is high and arready/awready is low (AXI stability).

Decomposition:
- Package sram_axi_pkg: AXI constants (BURST_INCR, LEN_SINGLE), size encodings, write FSM state enum.
- Sub-module rr_arbiter (parameter N; inputs req vector and enable; outputs one-hot grant; owns the pointer register).
- Top instantiates one rr_arbiter, with eligibility vectors computed outside it.

Test Plan:
- Single read, port 0, addr 0x1C000000, arready=1 and rvalid 2 cycles later with rdata 0xDEADBEEF -> arid=0, arsize=2, data_ok[0] with rdata 0xDEADBEEF, rd_cnt back to 0.
- Ports 0 and 1 reading continuously for 8 cycles, arready=1 -> grants alternate 0,1,0,1. Each port stops at 2 outstanding until an R beat with its ID returns. Out-of-order rid (1 before 0) is routed correctly.
- Write port 1, addr 0x100, wstrb 4'b0011, size 1, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles, awsize=1, data_ok[1] on bvalid.
- Port 1 writes 0x200 while port 0 reads 0x200 -> the read is not granted until bvalid, then proceeds. A read of 0x204 in the same window is granted immediately.
- aresetn pulled low while in W_REQ with two reads outstanding -> all valids drop asynchronously. After release, the first request is arbitrated from port 0 with counters zero.
